// File: rtl/bus_mux_pkg.sv
// rtl/bus_mux_pkg.sv - shared constants and types for the datapath bus multiplexer
package bus_mux_pkg;

    localparam int BUS_DATA_W    = 16;
    localparam int BUS_NARROW_W  = 8;
    localparam int BUS_NUM_SRC   = 8;
    localparam int BUS_SEL_W     = $clog2(BUS_NUM_SRC);

    typedef logic [BUS_SEL_W-1:0] sel_t;

    localparam sel_t SEL_DATAM = sel_t'(0);
    localparam sel_t SEL_INSTM = sel_t'(1);
    localparam sel_t SEL_PC    = sel_t'(2);
    localparam sel_t SEL_R     = sel_t'(3);
    localparam sel_t SEL_S     = sel_t'(4);
    localparam sel_t SEL_T     = sel_t'(5);
    localparam sel_t SEL_U     = sel_t'(6);
    localparam sel_t SEL_AC    = sel_t'(7);

endpackage

// File: rtl/bus_src_extend.sv
// rtl/bus_src_extend.sv - zero-fills one bus source down to its narrow width when flagged narrow
module bus_src_extend #(
    parameter int DATA_W   = 16,
    parameter int NARROW_W = 8,
    parameter bit NARROW   = 1'b0
) (
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] ext
);

    // When NARROW_W equals DATA_W the shift yields 0 and the subtraction wraps to all ones.
    localparam logic [DATA_W-1:0] NARROW_KEEP = (DATA_W'(1) << NARROW_W) - DATA_W'(1);
    localparam logic [DATA_W-1:0] KEEP        = NARROW ? NARROW_KEEP : '1;

    assign ext = word & KEEP;

endmodule

// File: rtl/bus_mux_pipe.sv
// rtl/bus_mux_pipe.sv - registered datapath bus multiplexer with stall, select-error flag and debug counters
module bus_mux_pipe
    import bus_mux_pkg::*;
#(
    parameter int              DATA_W      = BUS_DATA_W,
    parameter int              NUM_SRC     = BUS_NUM_SRC,
    parameter int              SEL_W       = $clog2(NUM_SRC),
    parameter int              NARROW_W    = BUS_NARROW_W,
    parameter logic [15:0]     NARROW_MASK = 16'b0000_0111,
    parameter int              CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        sel_valid,
    input  logic                        hold,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic                        err_clr,
    output logic [DATA_W-1:0]           bus,
    output logic                        bus_valid,
    output logic [SEL_W-1:0]            bus_src,
    output logic                        sel_err,
    output logic [CNT_W-1:0]            xfer_count,
    output logic [CNT_W-1:0]            err_count
);

    generate
        if (NARROW_W > DATA_W || NUM_SRC < 2 || NUM_SRC > 16 || SEL_W < 1) begin : g_bad_params
            $fatal(1, "bus_mux_pipe: illegal parameter combination");
        end
    endgenerate

    localparam logic [SEL_W:0] NUM_SRC_V = NUM_SRC[SEL_W:0];

    logic [DATA_W-1:0] ext [NUM_SRC];
    logic [DATA_W-1:0] mux_word;
    logic              accept;
    logic              legal;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        bus_src_extend #(
            .DATA_W   (DATA_W),
            .NARROW_W (NARROW_W),
            .NARROW   (NARROW_MASK[i])
        ) u_ext (
            .word (src_data[i*DATA_W +: DATA_W]),
            .ext  (ext[i])
        );
    end

    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_word = ext[i];
            end
        end
    end

    assign accept = sel_valid & ~hold;
    assign legal  = {1'b0, sel} < NUM_SRC_V;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus        <= '0;
            bus_valid  <= 1'b0;
            bus_src    <= '0;
            sel_err    <= 1'b0;
            xfer_count <= '0;
            err_count  <= '0;
        end else begin
            if (accept) begin
                bus_src <= sel;
                if (legal) begin
                    bus        <= mux_word;
                    bus_valid  <= 1'b1;
                    xfer_count <= xfer_count + CNT_W'(1);
                end else begin
                    bus       <= '0;
                    bus_valid <= 1'b0;
                end
            end else if (!hold) begin
                // Idle cycle: bus keeps its last value so late consumers can still sample it.
                bus_valid <= 1'b0;
            end

            if (err_clr) begin
                sel_err   <= 1'b0;
                err_count <= '0;
            end else if (accept && !legal) begin
                sel_err <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
